// File: rtl/l2_cache_assoc_if.sv
// Bundles the upstream line-request port and the physical-memory port of the L2 cache.
// The cache uses the slave modport; the surrounding environment (L1 arbiter + memory) uses master.
interface l2_cache_assoc_if #(
    parameter int ADDR_BITS = 16,
    parameter int LINE_BITS = 128
);
    logic                 mem_read;
    logic                 mem_write;
    logic [ADDR_BITS-1:0] mem_address;
    logic [LINE_BITS-1:0] mem_wdata;
    logic                 mem_resp;
    logic [LINE_BITS-1:0] mem_rdata;
    logic                 pmem_read;
    logic                 pmem_write;
    logic [ADDR_BITS-1:0] pmem_address;
    logic [LINE_BITS-1:0] pmem_wdata;
    logic [LINE_BITS-1:0] pmem_rdata;
    logic                 pmem_resp;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_resp, mem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_resp, mem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/l2_cache_assoc.sv
// N-way set-associative write-back L2 cache: true-LRU replacement, dirty write-back,
// write-allocate on miss, and saturating hit/miss counters.
module l2_cache_assoc #(
    parameter int WAYS      = 4,
    parameter int IDX_BITS  = 3,
    parameter int OFF_BITS  = 4,
    parameter int ADDR_BITS = 16,
    parameter int LINE_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    l2_cache_assoc_if.slave     bus,
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count
);
    localparam int SETS     = 2 ** IDX_BITS;
    localparam int TAG_BITS = ADDR_BITS - IDX_BITS - OFF_BITS;
    localparam int WAY_BITS = $clog2(WAYS);

    typedef enum logic [1:0] {IDLE, RESP, WRITEBACK, FILL} state_t;

    state_t state;

    logic [TAG_BITS-1:0]  tag_q  [SETS][WAYS];
    logic [LINE_BITS-1:0] data_q [SETS][WAYS];
    logic [WAY_BITS-1:0]  age_q  [SETS][WAYS];
    logic [WAYS-1:0]      valid_q [SETS];
    logic [WAYS-1:0]      dirty_q [SETS];

    logic [IDX_BITS-1:0] idx;
    logic [TAG_BITS-1:0] req_tag;
    logic                req;
    logic                is_write;
    logic                hit;
    logic [WAY_BITS-1:0] hit_way;
    logic [WAY_BITS-1:0] victim;
    logic                found_free;
    logic [WAY_BITS-1:0] victim_q;
    logic                unused_off;

    assign idx        = bus.mem_address[OFF_BITS+IDX_BITS-1:OFF_BITS];
    assign req_tag    = bus.mem_address[ADDR_BITS-1:OFF_BITS+IDX_BITS];
    assign req        = bus.mem_read | bus.mem_write;
    assign is_write   = bus.mem_write;
    assign unused_off = ^bus.mem_address[OFF_BITS-1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[idx][WAY_BITS'(w)] && tag_q[idx][WAY_BITS'(w)] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
        end
    end

    // Lowest-index invalid way wins; otherwise the oldest (age == WAYS-1) way.
    always_comb begin
        found_free = 1'b0;
        victim     = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!found_free && !valid_q[idx][WAY_BITS'(w)]) begin
                found_free = 1'b1;
                victim     = WAY_BITS'(w);
            end
        end
        if (!found_free) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age_q[idx][WAY_BITS'(w)] == WAY_BITS'(WAYS - 1)) victim = WAY_BITS'(w);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            victim_q         <= '0;
            bus.mem_resp     <= 1'b0;
            bus.mem_rdata    <= '0;
            bus.pmem_read    <= 1'b0;
            bus.pmem_write   <= 1'b0;
            bus.pmem_address <= '0;
            bus.pmem_wdata   <= '0;
            hit_count        <= '0;
            miss_count       <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[IDX_BITS'(s)] <= '0;
                dirty_q[IDX_BITS'(s)] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    age_q[IDX_BITS'(s)][WAY_BITS'(w)] <= WAY_BITS'(w);
                end
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (req && hit) begin
                        if (is_write) dirty_q[idx][hit_way] <= 1'b1;
                        else          bus.mem_rdata <= data_q[idx][hit_way];
                        for (int unsigned w = 0; w < WAYS; w++) begin
                            if (age_q[idx][WAY_BITS'(w)] < age_q[idx][hit_way])
                                age_q[idx][WAY_BITS'(w)] <= age_q[idx][WAY_BITS'(w)] + 1'b1;
                        end
                        age_q[idx][hit_way] <= '0;
                        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                        bus.mem_resp <= 1'b1;
                        state        <= RESP;
                    end else if (req) begin
                        victim_q <= victim;
                        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                        if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
                            bus.pmem_write   <= 1'b1;
                            bus.pmem_address <= {tag_q[idx][victim], idx, {OFF_BITS{1'b0}}};
                            bus.pmem_wdata   <= data_q[idx][victim];
                            state            <= WRITEBACK;
                        end else begin
                            bus.pmem_read    <= 1'b1;
                            bus.pmem_address <= {req_tag, idx, {OFF_BITS{1'b0}}};
                            state            <= FILL;
                        end
                    end
                end
                RESP: begin
                    bus.mem_resp <= 1'b0;
                    state        <= IDLE;
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        dirty_q[idx][victim_q] <= 1'b0;
                        bus.pmem_write         <= 1'b0;
                        bus.pmem_read          <= 1'b1;
                        bus.pmem_address       <= {req_tag, idx, {OFF_BITS{1'b0}}};
                        state                  <= FILL;
                    end
                end
                FILL: begin
                    // The fill leaves LRU untouched; the re-lookup hit in IDLE ages the set.
                    if (bus.pmem_resp) begin
                        valid_q[idx][victim_q] <= 1'b1;
                        dirty_q[idx][victim_q] <= 1'b0;
                        bus.pmem_read          <= 1'b0;
                        state                  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req && hit && is_write) data_q[idx][hit_way] <= bus.mem_wdata;
        if (state == FILL && bus.pmem_resp) begin
            data_q[idx][victim_q] <= bus.pmem_rdata;
            tag_q[idx][victim_q]  <= req_tag;
        end
    end
endmodule

// File: tb/tb_l2_cache_assoc.sv
// Self-checking bench for l2_cache_assoc: directed scenarios then random traffic,
// checked against a recency-list cache model and a sparse backing-memory model.
module tb_l2_cache_assoc;
    localparam int WAYS = 4;
    localparam int SETS = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int errors = 0;
    int checks = 0;

    l2_cache_assoc_if #(.ADDR_BITS(16), .LINE_BITS(128)) bus ();

    l2_cache_assoc #(
        .WAYS(WAYS), .IDX_BITS(3), .OFF_BITS(4), .ADDR_BITS(16), .LINE_BITS(128)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Reference model: per-set ways plus a recency list (index 0 = most recent).
    bit           m_valid [SETS][WAYS];
    bit           m_dirty [SETS][WAYS];
    logic [8:0]   m_tag   [SETS][WAYS];
    logic [127:0] m_data  [SETS][WAYS];
    int           m_order [SETS][WAYS];
    logic [127:0] pmem_store [logic [15:0]];
    int unsigned  exp_hit, exp_miss;
    bit           saw_d_wb;
    logic [127:0] line_d;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pmem_line(input logic [15:0] la);
        if (pmem_store.exists(la)) return pmem_store[la];
        return {la, ~la, la ^ 16'h5A5A, 16'hC0DE, la + 16'd7, ~la ^ 16'h1234, la, 16'hBEEF};
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_order[s][w] = w;
            end
        exp_hit  = 0;
        exp_miss = 0;
    endtask

    task automatic touch(input int s, input int w);
        int p = 0;
        for (int i = 0; i < WAYS; i++) if (m_order[s][i] == w) p = i;
        for (int i = p; i > 0; i--) m_order[s][i] = m_order[s][i-1];
        m_order[s][0] = w;
    endtask

    task automatic access(input bit rd, input bit wr, input logic [15:0] addr, input logic [127:0] wd);
        int s, hw, v, cyc, fill_cyc, wait_n;
        bit exp_wb, exp_fill, wb_seen, fill_seen, done;
        logic [15:0]  wb_addr, fill_addr;
        logic [127:0] wb_data, fill_data, exp_rd;
        logic [8:0]   tg;
        s = int'(addr[6:4]);
        tg = addr[15:7];
        hw = -1;
        for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == tg) hw = w;
        exp_wb = 1'b0; exp_fill = 1'b0;
        wb_addr = '0; wb_data = '0; fill_addr = '0; fill_data = '0;
        if (hw < 0) begin
            if (exp_miss < 65535) exp_miss++;
            v = -1;
            for (int w = 0; w < WAYS; w++) if (v < 0 && !m_valid[s][w]) v = w;
            if (v < 0) v = m_order[s][WAYS-1];
            if (m_valid[s][v] && m_dirty[s][v]) begin
                exp_wb  = 1'b1;
                wb_addr = {m_tag[s][v], addr[6:4], 4'h0};
                wb_data = m_data[s][v];
                pmem_store[wb_addr] = wb_data;
            end
            exp_fill  = 1'b1;
            fill_addr = {addr[15:4], 4'h0};
            fill_data = pmem_line(fill_addr);
            m_valid[s][v] = 1'b1;
            m_dirty[s][v] = 1'b0;
            m_tag[s][v]   = tg;
            m_data[s][v]  = fill_data;
            hw = v;
        end
        if (exp_hit < 65535) exp_hit++;
        touch(s, hw);
        if (wr) begin
            m_data[s][hw]  = wd;
            m_dirty[s][hw] = 1'b1;
        end
        exp_rd = m_data[s][hw];

        @(negedge clk);
        bus.mem_read = rd; bus.mem_write = wr; bus.mem_address = addr; bus.mem_wdata = wd;
        wait_n = $urandom_range(0, 2);
        cyc = 0; done = 1'b0; wb_seen = 1'b0; fill_seen = 1'b0; fill_cyc = -2;
        @(posedge clk); #1;
        check("first_pmem_write", bus.pmem_write, exp_wb);
        check("first_pmem_read", bus.pmem_read, exp_fill && !exp_wb);
        check("first_mem_resp", bus.mem_resp, !exp_fill);
        while (!done && cyc < 64) begin
            if (bus.mem_resp) begin
                done = 1'b1;
                check("wb_seen", wb_seen, exp_wb);
                check("fill_seen", fill_seen, exp_fill);
                check("latency", cyc, exp_fill ? fill_cyc + 2 : 0);
                if (!wr) check("mem_rdata", bus.mem_rdata, exp_rd);
                check("hit_count", hit_count, exp_hit);
                check("miss_count", miss_count, exp_miss);
                bus.mem_read = 1'b0; bus.mem_write = 1'b0;
            end else if (bus.pmem_write || bus.pmem_read) begin
                if (wait_n > 0) wait_n--;
                else begin
                    if (bus.pmem_write) begin
                        wb_seen = 1'b1;
                        check("wb_addr", bus.pmem_address, wb_addr);
                        check("wb_data", bus.pmem_wdata, wb_data);
                        check("wb_no_read", bus.pmem_read, 1'b0);
                        if (bus.pmem_address == 16'h0080 && bus.pmem_wdata == line_d) saw_d_wb = 1'b1;
                    end else begin
                        fill_seen = 1'b1;
                        check("fill_addr", bus.pmem_address, fill_addr);
                        bus.pmem_rdata = fill_data;
                        fill_cyc = cyc;
                    end
                    bus.pmem_resp = 1'b1;
                    wait_n = $urandom_range(0, 2);
                end
            end
            if (!done) begin
                @(posedge clk); #1;
                bus.pmem_resp = 1'b0;
                cyc++;
            end
        end
        if (!done) begin
            check("mem_resp_timeout", bus.mem_resp, 1'b1);
            bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        end else begin
            @(posedge clk); #1;
            check("resp_one_cycle", bus.mem_resp, 1'b0);
        end
    endtask

    initial begin
        logic [127:0] w_line;
        logic [15:0]  a;
        int op;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_address = '0; bus.mem_wdata = '0;
        bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
        saw_d_wb = 1'b0;
        line_d = {4{32'hD00D_F00D}};
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_resp", bus.mem_resp, 1'b0);
        check("rst_mem_rdata", bus.mem_rdata, '0);
        check("rst_pmem_read", bus.pmem_read, 1'b0);
        check("rst_pmem_write", bus.pmem_write, 1'b0);
        check("rst_pmem_address", bus.pmem_address, '0);
        check("rst_hit_count", hit_count, '0);
        check("rst_miss_count", miss_count, '0);
        @(negedge clk) rst_n = 1'b1;

        // Single read miss, fill, counters
        access(1, 0, 16'h0040, '0);
        check("t1_miss_count", miss_count, 16'd1);
        check("t1_hit_count", hit_count, 16'd1);

        // Fill set 0, touch way0, then clean eviction of way1
        access(1, 0, 16'h0000, '0);
        access(1, 0, 16'h0080, '0);
        access(1, 0, 16'h0100, '0);
        access(1, 0, 16'h0180, '0);
        access(1, 0, 16'h0000, '0);
        access(1, 0, 16'h0200, '0);
        access(1, 0, 16'h0104, '0);

        // Dirty line D at 0x0080, then force it out
        access(1, 0, 16'h0080, '0);
        access(0, 1, 16'h0080, line_d);
        access(1, 0, 16'h0400, '0);
        access(1, 0, 16'h0480, '0);
        access(1, 0, 16'h0500, '0);
        access(1, 0, 16'h0580, '0);
        check("t3_dirty_evict_0080", saw_d_wb, 1'b1);

        // Write-allocate miss then read back as a hit
        w_line = {$urandom, $urandom, $urandom, $urandom};
        access(0, 1, 16'h0300, w_line);
        access(1, 0, 16'h0300, '0);

        // Stray pmem_resp while idle must not disturb anything
        @(negedge clk) bus.pmem_resp = 1'b1;
        @(negedge clk) bus.pmem_resp = 1'b0;
        access(1, 0, 16'h0300, '0);

        // Reset during FILL
        @(negedge clk);
        bus.mem_read = 1'b1; bus.mem_address = 16'hFF00;
        @(posedge clk); #1;
        check("t5_fill_pmem_read", bus.pmem_read, 1'b1);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("t5_rst_pmem_read", bus.pmem_read, 1'b0);
        check("t5_rst_pmem_address", bus.pmem_address, '0);
        bus.mem_read = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        #1;
        check("t5_hit_count", hit_count, '0);
        check("t5_miss_count", miss_count, '0);
        access(1, 0, 16'h0300, '0);
        check("t5_reread_misses", miss_count, 16'd1);

        // Saturation of hit_count; read+write together behaves as a write
        @(negedge clk);
        force dut.hit_count = 16'hFFFE;
        #1 release dut.hit_count;
        exp_hit = 16'hFFFE;
        access(1, 0, 16'h0300, '0);
        access(1, 0, 16'h0300, '0);
        check("t6_hit_saturated", hit_count, 16'hFFFF);
        w_line = {$urandom, $urandom, $urandom, $urandom};
        access(1, 1, 16'h0300, w_line);
        access(1, 0, 16'h0300, '0);

        // Random traffic over two sets with more tags than ways
        for (int n = 0; n < 200; n++) begin
            a  = 16'(($urandom_range(0, 5) << 7) | ($urandom_range(0, 1) << 4) | $urandom_range(0, 15));
            op = $urandom_range(0, 3);
            access(op != 1, op == 1 || op == 2, a, {$urandom, $urandom, $urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
